// File: rtl/data_mem_handler_pkg.sv
// Shared types, encodings and constants for the data-memory load/store handler.
package data_mem_handler_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } store_f3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // Loads and stores share the size field in funct3[1:0]; unused encodings act as word.
    function automatic size_e access_size(input logic [2:0] f3);
        size_e sz;
        case ({1'b0, f3[1:0]})
            ST_SB:   sz = SZ_BYTE;
            ST_SH:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_unsigned_load(input logic [2:0] f3);
        return (f3 == LD_LBU) || (f3 == LD_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (access_size(f3))
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_handler_lane_align.sv
// Byte-lane alignment: byte-enable generation, store-data replication and load extract/extend.
module mem_lane_align
    import data_mem_handler_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      byte_en_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] ldata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        sign_ext;

    assign ld_byte  = rdata_i[{off_i, 3'b000} +: 8];
    assign ld_half  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign sign_ext = ~is_unsigned_load(funct3_i);

    always_comb begin
        byte_en_o = 4'b1111;
        wdata_o   = store_data_i;
        ldata_o   = rdata_i;
        case (access_size(funct3_i))
            SZ_BYTE: begin
                byte_en_o = 4'b0001 << off_i;
                wdata_o   = {4{store_data_i[7:0]}};
                ldata_o   = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                byte_en_o = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o   = {2{store_data_i[15:0]}};
                ldata_o   = {{16{sign_ext & ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_handler.sv
// Load/store data-bus handler: one bus transaction per request, core stalled until completion.
// Build option MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus strobe.
module data_mem_handler
    import data_mem_handler_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] aluResult,
    input  logic [XLEN-1:0] storeData,
    input  logic            memRead,
    input  logic            memWrite,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] busAddr,
    output logic [XLEN-1:0] busWData,
    output logic [3:0]      busByteEn,
    output logic            busRead,
    output logic            busWrite,
    input  logic            busBusy,
    input  logic [XLEN-1:0] busRData,
    output logic [XLEN-1:0] loadData,
    output logic            stall,
    output logic            done,
    output logic            busError,
    output logic            misaligned
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              write_q, write_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic              bus_read_q, bus_read_d;
    logic              bus_write_q, bus_write_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              done_q, done_d;
    logic              bus_err_q, bus_err_d;
    logic              req;
    logic              issue;
    logic [2:0]        lane_f3;
    logic [1:0]        lane_off;
    logic [3:0]        lane_be;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   lane_ldata;

    assign req     = memRead | memWrite;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Lanes follow the live request while idle, the latched access afterwards.
    assign lane_f3  = (state_q == S_IDLE) ? funct3 : f3_q;
    assign lane_off = (state_q == S_IDLE) ? aluResult[1:0] : off_q;

    mem_lane_align u_lane (
        .funct3_i     (lane_f3),
        .off_i        (lane_off),
        .store_data_i (storeData),
        .rdata_i      (busRData),
        .byte_en_o    (lane_be),
        .wdata_o      (lane_wdata),
        .ldata_o      (lane_ldata)
    );

`ifdef MISALIGN_CHECK_EN
    logic misal_q, misal_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        off_d       = off_q;
        write_d     = write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_read_d  = 1'b0;
        bus_write_d = 1'b0;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        bus_err_d   = 1'b0;
        issue       = 1'b0;
`ifdef MISALIGN_CHECK_EN
        misal_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    f3_d    = funct3;
                    off_d   = aluResult[1:0];
                    write_d = memWrite;
`ifdef MISALIGN_CHECK_EN
                    if (is_misaligned(funct3, aluResult[1:0])) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        misal_d = 1'b1;
                    end else begin
                        issue = 1'b1;
                    end
`else
                    issue = 1'b1;
`endif
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!busBusy) begin
                    if (!write_q) begin
                        load_data_d = lane_ldata;
                    end
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        bus_err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Simultaneous read and write requests resolve to a write.
        if (issue) begin
            state_d     = S_REQ;
            bus_addr_d  = {aluResult[XLEN-1:2], 2'b00};
            bus_wdata_d = lane_wdata;
            bus_be_d    = lane_be;
            bus_read_d  = ~memWrite;
            bus_write_d = memWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            write_q     <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            write_q     <= write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misal_q <= 1'b0;
        end else begin
            misal_q <= misal_d;
        end
    end
    assign misaligned = misal_q;
`else
    assign misaligned = 1'b0;
`endif

    // The core must freeze in the very cycle a request first appears.
    assign stall = ((state_q == S_IDLE) && req) || (state_q == S_REQ) || (state_q == S_WAIT);

    assign busAddr   = bus_addr_q;
    assign busWData  = bus_wdata_q;
    assign busByteEn = bus_be_q;
    assign busRead   = bus_read_q;
    assign busWrite  = bus_write_q;
    assign loadData  = load_data_q;
    assign done      = done_q;
    assign busError  = bus_err_q;

endmodule

// File: tb/tb_data_mem_handler.sv
// Scoreboard bench for data_mem_handler: random loads/stores against a behavioural memory-access model.
module tb_data_mem_handler;

    localparam int TB_TIMEOUT = 5;

    logic        clk;
    logic        rst;
    logic [31:0] aluResult;
    logic [31:0] storeData;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  busByteEn;
    logic        busRead;
    logic        busWrite;
    logic        busBusy;
    logic [31:0] busRData;
    logic [31:0] loadData;
    logic        stall;
    logic        done;
    logic        busError;
    logic        misaligned;

    data_mem_handler #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluResult  (aluResult),
        .storeData  (storeData),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .funct3     (funct3),
        .busAddr    (busAddr),
        .busWData   (busWData),
        .busByteEn  (busByteEn),
        .busRead    (busRead),
        .busWrite   (busWrite),
        .busBusy    (busBusy),
        .busRData   (busRData),
        .loadData   (loadData),
        .stall      (stall),
        .done       (done),
        .busError   (busError),
        .misaligned (misaligned)
    );

    typedef struct {
        logic [31:0] load;
        logic        err;
        logic        mis;
        int          rd;
        int          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          mem_busy_n = 0;
    logic [31:0] last_load = '0;

    logic [2:0]  ld_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  st_ops [3] = '{3'd0, 3'd1, 3'd2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Memory: after a strobe, hold busBusy for the requested number of WAIT cycles.
    initial begin
        busBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (busRead || busWrite) begin
                @(posedge clk); #1;
                for (int i = 0; i < mem_busy_n; i++) begin
                    if (!stall || rst) break;
                    busBusy = 1'b1;
                    @(posedge clk); #1;
                end
                busBusy = 1'b0;
            end
        end
    end

    // Monitor: track each transaction from first request to done, then score it.
    int          m_t, m_stalls, m_rd, m_wr;
    logic        m_active = 1'b0;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_active = 1'b0;
            end else begin
                if (m_active) begin
                    m_t++;
                end else if (memRead || memWrite) begin
                    m_active = 1'b1;
                    m_t = 0; m_stalls = 0; m_rd = 0; m_wr = 0;
                    m_addr = '0; m_wdata = '0; m_be = '0;
                end
                if (m_active) begin
                    if (stall) m_stalls++;
                    if (busRead)  m_rd++;
                    if (busWrite) m_wr++;
                    if (busRead || busWrite) begin
                        m_addr = busAddr; m_be = busByteEn; m_wdata = busWData;
                    end
                    if (done) begin
                        m_active = 1'b0;
                        if (sb_q.size() == 0) begin
                            n_checks++; n_err++;
                            $display("FAIL done_without_request: got done=1, expected no pending transaction");
                        end else begin
                            e = sb_q.pop_front();
                            chk("loadData",   loadData,            e.load);
                            chk("busError",   32'(busError),       32'(e.err));
                            chk("misaligned", 32'(misaligned),     32'(e.mis));
                            chk("latency",    32'(m_t),            32'(e.lat));
                            chk("stall_cyc",  32'(m_stalls),       32'(e.lat));
                            chk("read_strb",  32'(m_rd),           32'(e.rd));
                            chk("write_strb", 32'(m_wr),           32'(e.wr));
                            if (e.rd + e.wr > 0) begin
                                chk("busAddr",      m_addr,        e.addr);
                                chk("busAddr_hold", busAddr,       e.addr);
                                chk("busByteEn",    32'(m_be),     32'(e.be));
                            end
                            if (e.wr > 0) chk("busWData", m_wdata, e.wdata);
                        end
                    end
                end else if (done) begin
                    n_checks++; n_err++;
                    $display("FAIL spurious_done: got done=1, expected 0");
                end
            end
        end
    end

    // Reference model of one access, then drive the request until done.
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int busy, input logic both);
        exp_t        e;
        int          off, sz, lane;
        logic [31:0] ext, mask;
        logic        got;
        off  = int'(addr[1:0]);
        sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lane = off - (off % sz);
`ifdef MISALIGN_CHECK_EN
        e.mis = ((off % sz) != 0);
`else
        e.mis = 1'b0;
`endif
        e.err   = !e.mis && (busy >= TB_TIMEOUT);
        e.lat   = e.mis ? 1 : (e.err ? TB_TIMEOUT + 2 : busy + 3);
        e.rd    = (!e.mis && !wr) ? 1 : 0;
        e.wr    = (!e.mis && wr) ? 1 : 0;
        e.addr  = addr & 32'hFFFF_FFFC;
        e.be    = 4'(((1 << sz) - 1) << lane);
        e.wdata = (sz == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                  (sz == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
        ext = rdata >> (8 * lane);
        if (sz < 4) begin
            mask = (32'h1 << (8 * sz)) - 32'h1;
            ext  = ext & mask;
            if (!f3[2] && ext[8 * sz - 1]) ext = ext | ~mask;
        end
        if (!wr && !e.mis && !e.err) last_load = ext;
        e.load = last_load;
        sb_q.push_back(e);

        mem_busy_n = busy;
        aluResult  = addr;
        funct3     = f3;
        storeData  = sdata;
        busRData   = rdata;
        memWrite   = wr;
        memRead    = !wr || both;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        wr, both;
        logic [2:0]  f3;
        rst = 1'b1;
        aluResult = '0; storeData = '0; memRead = 1'b0; memWrite = 1'b0;
        funct3 = '0; busRData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",    32'(stall),      32'd0);
        chk("rst_busRead",  32'(busRead),    32'd0);
        chk("rst_busWrite", 32'(busWrite),   32'd0);
        chk("rst_done",     32'(done),       32'd0);
        chk("rst_busError", 32'(busError),   32'd0);
        chk("rst_misalign", 32'(misaligned), 32'd0);
        chk("rst_loadData", loadData,        32'd0);
        chk("rst_busAddr",  busAddr,         32'd0);
        chk("rst_busByteEn", 32'(busByteEn), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0,   1'b0);
        run_txn(1'b0, 3'd0, 32'h0000_0103, 32'h0,         32'h80FF_FFFF, 0,   1'b0);
        run_txn(1'b0, 3'd4, 32'h0000_0103, 32'h0,         32'h80FF_FFFF, 0,   1'b0);
        run_txn(1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0,         4,   1'b0);
        run_txn(1'b0, 3'd2, 32'h0000_0104, 32'h0,         32'h1111_2222, 100, 1'b0);
        run_txn(1'b0, 3'd2, 32'h0000_0101, 32'h0,         32'hCAFE_F00D, 0,   1'b0);
        run_txn(1'b1, 3'd2, 32'h0000_0300, 32'hA5A5_5A5A, 32'h0,         1,   1'b1);
        run_txn(1'b0, 3'd5, 32'h0000_0106, 32'h0,         32'h8001_7FFE, 2,   1'b0);

        // Reset while waiting on a busy bus.
        mem_busy_n = 50;
        aluResult = 32'h0000_0400; funct3 = 3'd2; memRead = 1'b1; memWrite = 1'b0;
        busRData = 32'h5A5A_5A5A;
        repeat (4) begin @(posedge clk); #1; end
        chk("stall_in_wait", 32'(stall), 32'd1);
        rst = 1'b1;
        memRead = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_load = '0;
        @(negedge clk);
        chk("midrst_stall",    32'(stall),   32'd0);
        chk("midrst_busRead",  32'(busRead), 32'd0);
        chk("midrst_loadData", loadData,     32'd0);
        chk("midrst_done",     32'(done),    32'd0);
        repeat (2) begin @(posedge clk); #1; end
        run_txn(1'b0, 3'd2, 32'h0000_0108, 32'h0, 32'h0BAD_F00D, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            wr   = 1'($urandom_range(0, 1));
            f3   = wr ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
            both = wr && ($urandom_range(0, 3) == 0);
            run_txn(wr, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 7)), both);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
